// File: rtl/exposure_pkg.sv
// -----------------------------------------------------------------------------
// exposure_pkg
// Shared types and constants for the ToF exposure controller:
//   - cnt_t       : 16-bit timer / frame-counter word
//   - state_t     : exposure FSM states (binary encoded)
//   - phase_t     : modulation phase select codes (0/90/180/270 degrees)
//   - next_phase(): phase index advance with wrap at the configured count
// -----------------------------------------------------------------------------
package exposure_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRES    = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_GUARD   = 3'd3,
    ST_REQ     = 3'd4,
    ST_WAIT_RO = 3'd5,
    ST_ACK     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_0   = 2'd0,
    PH_90  = 2'd1,
    PH_180 = 2'd2,
    PH_270 = 2'd3
  } phase_t;

  // Advance the phase index, wrapping to PH_0 after the last configured phase.
  function automatic phase_t next_phase(input phase_t idx, input int num_phases);
    if (int'(idx) >= num_phases - 1) begin
      return PH_0;
    end
    return phase_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/exposure_ctrl_if.sv
// -----------------------------------------------------------------------------
// exposure_ctrl_if
// Readout handshake between the exposure controller and the readout engine.
//   FSMIND0     engine -> ctrl : readout engine idle / readout done
//   FSMIND0ACK  ctrl -> engine : acknowledge of readout done (1-cycle pulse)
//   FSMIND1     ctrl -> engine : request readout of the exposed frame
//   FSMIND1ACK  engine -> ctrl : engine accepted the request
// Modports: master = exposure controller, slave = readout engine.
// -----------------------------------------------------------------------------
interface exposure_ctrl_if;

  logic FSMIND0;
  logic FSMIND0ACK;
  logic FSMIND1;
  logic FSMIND1ACK;

  modport master (
    input  FSMIND0,
    input  FSMIND1ACK,
    output FSMIND0ACK,
    output FSMIND1
  );

  modport slave (
    output FSMIND0,
    output FSMIND1ACK,
    input  FSMIND0ACK,
    input  FSMIND1
  );

endinterface

// File: rtl/exp_timer.sv
// -----------------------------------------------------------------------------
// exp_timer
// Loadable 16-bit down-counter shared by the GRES, EXPOSE and GUARD phases.
//   ADC_PIXCLK in  : clock, rising edge
//   RESET      in  : asynchronous active-high reset
//   load       in  : load load_val on this edge (takes priority over counting)
//   load_val   in  : phase length in cycles
//   done       out : phase ends on the coming edge
// A phase loaded with N lasts N cycles; N = 0 and N = 1 both last one cycle,
// which gives the "zero means one" behaviour for exposure and guard time.
// -----------------------------------------------------------------------------
module exp_timer
  import exposure_pkg::*;
(
  input  logic ADC_PIXCLK,
  input  logic RESET,
  input  logic load,
  input  cnt_t load_val,
  output logic done
);

  cnt_t cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge ADC_PIXCLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - cnt_t'(1);
    end
  end

  assign done = (cnt_q <= cnt_t'(1));

endmodule

// File: rtl/exposure_ctrl.sv
// -----------------------------------------------------------------------------
// exposure_ctrl
// Sequences one ToF phase sub-frame at a time:
//   global reset -> exposure (modulation on) -> guard -> readout request
//   -> wait for readout done -> acknowledge, advance phase / frame count.
// Parameters:
//   C_GRES_CNT    global reset length in cycles
//   C_GUARD_CNT   dead time between exposure and readout request
//   C_NUM_PHASES  phase sub-frames per frame, 1..4
// Ports:
//   ADC_PIXCLK          in  : sole clock
//   RESET               in  : asynchronous active-high reset
//   START_EN            in  : run enable, sampled in IDLE and ACK only
//   EXP_LEN[15:0]       in  : exposure length, latched when entering GRES
//   GLOB_RES            out : global pixel reset
//   DRAIN_B             out : modulation enable
//   CLK_MOD_PHASE_SEL1  out : phase select low bit
//   CLK_MOD_PHASE_SEL2  out : phase select high bit
//   PHASE_IDX[1:0]      out : current phase index
//   FRAME_CNT[15:0]     out : completed full frames (wraps)
//   BUSY                out : high outside IDLE
//   ro                  if  : readout handshake, master side
// Every output is a flop; strobes are computed from the next state so they
// line up exactly with the state register.
// -----------------------------------------------------------------------------
module exposure_ctrl
  import exposure_pkg::*;
#(
  parameter int C_GRES_CNT   = 20,
  parameter int C_GUARD_CNT  = 4,
  parameter int C_NUM_PHASES = 4
) (
  input  logic             ADC_PIXCLK,
  input  logic             RESET,
  input  logic             START_EN,
  input  logic [CNT_W-1:0] EXP_LEN,
  output logic             GLOB_RES,
  output logic             DRAIN_B,
  output logic             CLK_MOD_PHASE_SEL1,
  output logic             CLK_MOD_PHASE_SEL2,
  output logic [1:0]       PHASE_IDX,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             BUSY,
  exposure_ctrl_if.master  ro
);

  localparam cnt_t GRES_LEN  = cnt_t'(C_GRES_CNT);
  localparam cnt_t GUARD_LEN = cnt_t'(C_GUARD_CNT);

  state_t state_q, state_n;
  cnt_t   exp_len_q, exp_len_n;
  phase_t phase_q, phase_n;
  cnt_t   frame_cnt_q, frame_cnt_n;

  logic   glob_res_q, drain_b_q, fsmind1_q, fsmind0ack_q, busy_q;

  logic   tmr_load;
  cnt_t   tmr_val;
  logic   tmr_done;

  exp_timer u_timer (
    .ADC_PIXCLK (ADC_PIXCLK),
    .RESET      (RESET),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .done       (tmr_done)
  );

  // Next-state, phase bookkeeping and timer loads.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n     = state_q;
    exp_len_n   = exp_len_q;
    phase_n     = phase_q;
    frame_cnt_n = frame_cnt_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (START_EN && ro.FSMIND0) begin
          state_n   = ST_GRES;
          exp_len_n = EXP_LEN;
          tmr_load  = 1'b1;
          tmr_val   = GRES_LEN;
        end
      end
      ST_GRES: begin
        if (tmr_done) begin
          state_n  = ST_EXPOSE;
          tmr_load = 1'b1;
          tmr_val  = exp_len_q;
        end
      end
      ST_EXPOSE: begin
        if (tmr_done) begin
          state_n  = ST_GUARD;
          tmr_load = 1'b1;
          tmr_val  = GUARD_LEN;
        end
      end
      ST_GUARD: begin
        if (tmr_done) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        // Held indefinitely until the engine accepts; no timeout.
        if (ro.FSMIND1ACK) begin
          state_n = ST_WAIT_RO;
        end
      end
      ST_WAIT_RO: begin
        if (ro.FSMIND0) begin
          state_n = ST_ACK;
        end
      end
      ST_ACK: begin
        phase_n = next_phase(phase_q, C_NUM_PHASES);
        if (phase_n == PH_0) begin
          frame_cnt_n = frame_cnt_q + cnt_t'(1);
        end
        // A START_EN drop anywhere mid-frame only takes effect here.
        if (START_EN) begin
          state_n   = ST_GRES;
          exp_len_n = EXP_LEN;
          tmr_load  = 1'b1;
          tmr_val   = GRES_LEN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ADC_PIXCLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      exp_len_q    <= '0;
      phase_q      <= PH_0;
      frame_cnt_q  <= '0;
      glob_res_q   <= 1'b0;
      drain_b_q    <= 1'b0;
      fsmind1_q    <= 1'b0;
      fsmind0ack_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      exp_len_q    <= exp_len_n;
      phase_q      <= phase_n;
      frame_cnt_q  <= frame_cnt_n;
      glob_res_q   <= (state_n == ST_GRES);
      drain_b_q    <= (state_n == ST_EXPOSE);
      fsmind1_q    <= (state_n == ST_REQ);
      fsmind0ack_q <= (state_n == ST_ACK);
      busy_q       <= (state_n != ST_IDLE);
    end
  end

  assign GLOB_RES           = glob_res_q;
  assign DRAIN_B            = drain_b_q;
  assign PHASE_IDX          = phase_q;
  assign CLK_MOD_PHASE_SEL1 = phase_q[0];
  assign CLK_MOD_PHASE_SEL2 = phase_q[1];
  assign FRAME_CNT          = frame_cnt_q;
  assign BUSY               = busy_q;
  assign ro.FSMIND1         = fsmind1_q;
  assign ro.FSMIND0ACK      = fsmind0ack_q;

endmodule

// File: tb/tb_exposure_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exposure_ctrl
// Directed bench for exposure_ctrl. dut1 uses the default parameters with a
// readout-engine peer that acks after a programmable delay and reports done
// 50 cycles after the request. dut2 runs single-phase frames with short timing
// for the frame-counter wrap. A monitor turns GLOB_RES / DRAIN_B / FSMIND0ACK
// pulses of dut1 into events that are compared against an expected queue.
// -----------------------------------------------------------------------------
module tb_exposure_ctrl;
  import exposure_pkg::*;

  localparam int PEER_RO_DELAY = 50;

  typedef enum logic [1:0] {EV_NONE, EV_GRES, EV_DRAIN, EV_ACK} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] val;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_en, start_en2;
  logic [15:0] exp_len, exp_len2;
  logic        glob_res, drain_b, sel1, sel2, busy;
  logic [1:0]  phase_idx;
  logic [15:0] frame_cnt;
  logic        glob_res2, drain_b2, sel1_2, sel2_2, busy2;
  logic [1:0]  phase_idx2;
  logic [15:0] frame_cnt2;

  exposure_ctrl_if ro1 ();
  exposure_ctrl_if ro2 ();

  int       checks = 0;
  int       errors = 0;
  sb_item_t sb_q[$];
  int       ack_seen = 0;
  int       overlap = 0;
  int       overlap2 = 0;
  int       peer_ack_delay = 2;

  always #5 clk = ~clk;

  exposure_ctrl dut1 (
    .ADC_PIXCLK         (clk),
    .RESET              (rst),
    .START_EN           (start_en),
    .EXP_LEN            (exp_len),
    .GLOB_RES           (glob_res),
    .DRAIN_B            (drain_b),
    .CLK_MOD_PHASE_SEL1 (sel1),
    .CLK_MOD_PHASE_SEL2 (sel2),
    .PHASE_IDX          (phase_idx),
    .FRAME_CNT          (frame_cnt),
    .BUSY               (busy),
    .ro                 (ro1)
  );

  exposure_ctrl #(
    .C_GRES_CNT   (3),
    .C_GUARD_CNT  (0),
    .C_NUM_PHASES (1)
  ) dut2 (
    .ADC_PIXCLK         (clk),
    .RESET              (rst),
    .START_EN           (start_en2),
    .EXP_LEN            (exp_len2),
    .GLOB_RES           (glob_res2),
    .DRAIN_B            (drain_b2),
    .CLK_MOD_PHASE_SEL1 (sel1_2),
    .CLK_MOD_PHASE_SEL2 (sel2_2),
    .PHASE_IDX          (phase_idx2),
    .FRAME_CNT          (frame_cnt2),
    .BUSY               (busy2),
    .ro                 (ro2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare(input ev_kind_t kind, input logic [31:0] val);
    sb_item_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
    end else begin
      e.kind = EV_NONE;
      e.val  = '0;
    end
    check($sformatf("sb_kind_%s", kind.name()), 32'(kind), 32'(e.kind));
    check($sformatf("sb_val_%s", kind.name()), val, e.val);
  endtask

  // Expected events for one phase: reset length, exposure (sel, idx, length),
  // then the ack pulse (width, phase after ack, frame count after ack).
  task automatic push_phase(input logic [1:0] p, input int len,
                            input logic [15:0] frame_after);
    logic [1:0] nph;
    nph = p + 2'd1;
    sb_q.push_back('{EV_GRES,  32'd20});
    sb_q.push_back('{EV_DRAIN, {12'd0, p, p, 16'(len)}});
    sb_q.push_back('{EV_ACK,   {6'd0, 8'd1, nph, frame_after}});
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return busy;
      1:       return drain_b;
      2:       return ro1.FSMIND1;
      default: return ro2.FSMIND0ACK;
    endcase
  endfunction

  task automatic wait_high(input string tag, input int which, input int budget);
    int   i;
    logic s;
    i = 0;
    do begin
      @(negedge clk);
      i++;
      s = sig(which);
    end while (!s && i < budget);
    check(tag, 32'(s), 32'd1);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int i;
    i = 0;
    while (ack_seen < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("ack_count_%0d", n), ack_seen, n);
  endtask

  // Event monitor for dut1 plus overlap watch on both instances.
  initial begin
    int gres_run, drain_run, ack_run;
    logic [1:0] d_sel, d_ph;
    gres_run  = 0;
    drain_run = 0;
    ack_run   = 0;
    d_sel     = '0;
    d_ph      = '0;
    forever begin
      @(negedge clk);
      if (glob_res2 && drain_b2) overlap2++;
      if (rst) begin
        gres_run  = 0;
        drain_run = 0;
        ack_run   = 0;
      end else begin
        if (glob_res && drain_b) overlap++;
        if (glob_res) begin
          gres_run++;
        end else if (gres_run != 0) begin
          sb_compare(EV_GRES, 32'(gres_run));
          gres_run = 0;
        end
        if (drain_b) begin
          drain_run++;
          d_sel = {sel2, sel1};
          d_ph  = phase_idx;
        end else if (drain_run != 0) begin
          sb_compare(EV_DRAIN, {12'd0, d_sel, d_ph, 16'(drain_run)});
          drain_run = 0;
        end
        if (ro1.FSMIND0ACK) begin
          ack_run++;
        end else if (ack_run != 0) begin
          sb_compare(EV_ACK, {6'd0, 8'(ack_run), phase_idx, frame_cnt});
          ack_seen++;
          ack_run = 0;
        end
      end
    end
  end

  // Readout engine peer for dut1.
  initial begin
    ro1.FSMIND0    = 1'b1;
    ro1.FSMIND1ACK = 1'b0;
    forever begin
      @(negedge clk);
      if (ro1.FSMIND1 === 1'b1) begin
        ro1.FSMIND0 = 1'b0;
        repeat (peer_ack_delay) @(negedge clk);
        ro1.FSMIND1ACK = 1'b1;
        @(negedge clk);
        ro1.FSMIND1ACK = 1'b0;
        repeat (PEER_RO_DELAY - peer_ack_delay - 1) @(negedge clk);
        ro1.FSMIND0 = 1'b1;
      end
    end
  end

  // Fast readout engine peer for dut2.
  initial begin
    ro2.FSMIND0    = 1'b1;
    ro2.FSMIND1ACK = 1'b0;
    forever begin
      @(negedge clk);
      if (ro2.FSMIND1 === 1'b1) begin
        ro2.FSMIND0    = 1'b0;
        ro2.FSMIND1ACK = 1'b1;
        @(negedge clk);
        ro2.FSMIND1ACK = 1'b0;
        repeat (3) @(negedge clk);
        ro2.FSMIND0 = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, drn, ph_moves;
    rst       = 1'b1;
    start_en  = 1'b0;
    start_en2 = 1'b0;
    exp_len   = 16'd100;
    exp_len2  = 16'd2;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_glob_res", 32'(glob_res), 32'd0);
    check("rst_drain_b", 32'(drain_b), 32'd0);
    check("rst_fsmind1", 32'(ro1.FSMIND1), 32'd0);
    check("rst_fsmind0ack", 32'(ro1.FSMIND0ACK), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_phase", {28'd0, sel2, sel1, phase_idx}, 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full 4-phase frame with EXP_LEN=100
    for (int p = 0; p < 4; p++) push_phase(2'(p), 100, (p == 3) ? 16'd1 : 16'd0);
    start_en = 1'b1;
    wait_acks(3, 1500);
    start_en = 1'b0;
    wait_acks(4, 500);
    repeat (3) @(negedge clk);
    check("frame_busy", 32'(busy), 32'd0);
    check("frame_cnt_1", 32'(frame_cnt), 32'd1);
    check("frame_phase_wrap", 32'(phase_idx), 32'd0);
    check("frame_sb_drained", sb_q.size(), 0);

    // EXP_LEN=0 exposes for exactly one cycle
    exp_len = 16'd0;
    push_phase(2'd0, 1, 16'd1);
    start_en = 1'b1;
    wait_high("len0_busy", 0, 20);
    start_en = 1'b0;
    wait_acks(5, 500);
    repeat (3) @(negedge clk);
    check("len0_idle", 32'(busy), 32'd0);

    // START_EN dropped during EXPOSE of phase 1
    exp_len = 16'd100;
    push_phase(2'd1, 100, 16'd1);
    start_en = 1'b1;
    wait_high("drop_drain", 1, 100);
    start_en = 1'b0;
    wait_acks(6, 500);
    repeat (60) @(negedge clk);
    check("drop_single_ack", ack_seen, 6);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_phase", 32'(phase_idx), 32'd2);

    // Peer withholds FSMIND1ACK for 1000 cycles
    peer_ack_delay = 1000;
    exp_len = 16'd10;
    push_phase(2'd2, 10, 16'd1);
    start_en = 1'b1;
    wait_high("hold_busy", 0, 20);
    start_en = 1'b0;
    wait_high("hold_req", 2, 200);
    hi = 0;
    drn = 0;
    ph_moves = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ro1.FSMIND1) hi++;
      if (drain_b || glob_res) drn++;
      if (phase_idx != 2'd2) ph_moves++;
    end
    check("hold_fsmind1_cycles", hi, 1000);
    check("hold_strobes_low", drn, 0);
    check("hold_no_advance", ph_moves, 0);
    wait_acks(7, 500);
    peer_ack_delay = 2;
    repeat (5) @(negedge clk);

    // Asynchronous reset during EXPOSE
    exp_len = 16'd100;
    sb_q.push_back('{EV_GRES, 32'd20});
    start_en = 1'b1;
    wait_high("areset_busy", 0, 20);
    start_en = 1'b0;
    wait_high("areset_drain", 1, 100);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("areset_drain_b", 32'(drain_b), 32'd0);
    check("areset_busy_low", 32'(busy), 32'd0);
    check("areset_counters", {phase_idx, frame_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("areset_no_ack", ack_seen, 7);
    check("areset_idle", 32'(busy), 32'd0);
    check("areset_sb_drained", sb_q.size(), 0);

    // FRAME_CNT wrap on single-phase dut2
    force dut2.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut2.frame_cnt_q;
    @(negedge clk);
    check("wrap_preload", 32'(frame_cnt2), 32'hFFFF);
    start_en2 = 1'b1;
    wait_high("wrap_ack", 3, 200);
    start_en2 = 1'b0;
    check("wrap_before_edge", 32'(frame_cnt2), 32'hFFFF);
    @(negedge clk);
    check("wrap_frame_zero", 32'(frame_cnt2), 32'd0);
    check("wrap_phase_zero", 32'(phase_idx2), 32'd0);
    repeat (5) @(negedge clk);
    check("wrap_idle", 32'(busy2), 32'd0);

    check("no_overlap_dut1", overlap, 0);
    check("no_overlap_dut2", overlap2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exposure_ctrl.md
EXPOSURE_CTRL -- requirements
Module: exposure_ctrl

Interface
REQ-001 Parameter C_GRES_CNT, default 20: global pixel reset duration, in ADC_PIXCLK cycles.
REQ-002 Parameter C_GUARD_CNT, default 4: dead time after exposure before readout request, in cycles.
REQ-003 Parameter C_NUM_PHASES, default 4: ToF phase sub-frames per frame; legal range 1..4.
REQ-004 ADC_PIXCLK  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 START_EN  in  1  run enable; sampled only in IDLE and ACK.
REQ-007 EXP_LEN  in  16  exposure length in cycles; latched on IDLE->GRES and on ACK->GRES; value 0 treated as 1.
REQ-008 GLOB_RES  out  1  global pixel reset.
REQ-009 DRAIN_B  out  1  ToF modulation enable (gates CLK_MOD/CLKN_MOD downstream).
REQ-010 CLK_MOD_PHASE_SEL1  out  1  phase select, low bit.
REQ-011 CLK_MOD_PHASE_SEL2  out  1  phase select, high bit.
REQ-012 FSMIND0  in  1  readout engine idle / readout done.
REQ-013 FSMIND0ACK  out  1  acknowledge of readout done.
REQ-014 FSMIND1  out  1  request readout of exposed frame.
REQ-015 FSMIND1ACK  in  1  readout engine accepted request.
REQ-016 PHASE_IDX  out  2  current phase index.
REQ-017 FRAME_CNT  out  16  completed full-frame count.
REQ-018 BUSY  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, GRES, EXPOSE, GUARD, REQ, WAIT_RO, ACK; encoding is binary, from the package.
REQ-020 IDLE: all strobes low; START_EN=1 and FSMIND0=1 -> GRES next cycle.
REQ-021 GRES: GLOB_RES=1 for exactly C_GRES_CNT cycles, then EXPOSE.
REQ-022 EXPOSE: DRAIN_B=1 for exactly max(EXP_LEN_latched,1) cycles, then GUARD; GLOB_RES=0.
REQ-023 GUARD: DRAIN_B=0 for C_GUARD_CNT cycles, then REQ; C_GUARD_CNT=0 goes directly to REQ after one cycle.
REQ-024 REQ: FSMIND1=1, held until FSMIND1ACK=1 is sampled; then FSMIND1=0 and WAIT_RO; no timeout.
REQ-025 WAIT_RO: wait until FSMIND0=1 is sampled, then ACK.
REQ-026 ACK: FSMIND0ACK=1 for exactly one cycle.
REQ-026a ACK: PHASE_IDX advances by 1 and wraps to 0 after C_NUM_PHASES-1.
REQ-026b ACK: on wrap, FRAME_CNT increments, wrapping 0xFFFF->0.
REQ-026c ACK: next state is GRES if START_EN=1, else IDLE.
REQ-027 {CLK_MOD_PHASE_SEL2,CLK_MOD_PHASE_SEL1} = PHASE_IDX: 0=0 deg, 1=90 deg, 2=180 deg, 3=270 deg.
REQ-027a Phase selects change only on the ACK->next-state edge, never during GRES..REQ.
REQ-028 GLOB_RES and DRAIN_B are never high simultaneously.
REQ-029 All outputs are registered; no combinational path from inputs to outputs.
REQ-030 START_EN deassertion mid-frame does not abort; it takes effect at the next ACK.
REQ-031 FSMIND1ACK asserted outside REQ is ignored.
REQ-031a FSMIND0 changes outside IDLE/WAIT_RO are ignored.

Reset
REQ-032 On RESET, the state is IDLE, and GLOB_RES, DRAIN_B, FSMIND1, FSMIND0ACK, BUSY, PHASE_IDX, FRAME_CNT, phase selects and counters all clear to 0.
REQ-033 RESET mid-operation (any state) forces REQ-032 values immediately, without waiting for a clock edge.
REQ-033a After release, the block restarts from IDLE without issuing FSMIND0ACK.

Structure
REQ-034 Package exposure_pkg holds the state enum, phase-select constants, and counter width (16).
REQ-035 A single sub-module exp_timer (loadable 16-bit down-counter with done flag) times GRES, EXPOSE and GUARD.

Verification
REQ-036 C_NUM_PHASES=4, EXP_LEN=100, peer model answers FSMIND1 with ACK after 2 cycles and returns FSMIND0 after 50 cycles -> GLOB_RES 20 cycles, DRAIN_B exactly 100 cycles, phase selects 00,01,10,11, then FRAME_CNT=1.
REQ-037 EXP_LEN=0 -> DRAIN_B high exactly 1 cycle.
REQ-038 Peer withholds FSMIND1ACK for 1000 cycles -> FSMIND1 held high for the full 1000 cycles; no state advance; DRAIN_B=0.
REQ-039 START_EN dropped during EXPOSE of phase 1 -> phase 1 completes, a single FSMIND0ACK pulse occurs, then IDLE with PHASE_IDX=2 and BUSY=0.
REQ-040 RESET pulsed during EXPOSE -> DRAIN_B and BUSY go low before the next clock edge; counters read 0.
REQ-041 FRAME_CNT preloaded to 0xFFFF via forced run (C_NUM_PHASES=1) -> wraps to 0x0000; GLOB_RES and DRAIN_B are never high together.
